pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the 32-bit MIPS-style core.
- Holds the architectural PC and fetches one instruction at a time from instruction memory over a request/grant/response handshake.
- Feeds pc_plus4 and jpc downstream to the next-PC selector, and loads that selector's result (pc_in) when the current instruction commits.
- Single-issue, non-pipelined fetch with a response watchdog and a sticky fault.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/fetch_watchdog.sv | 32 +++
 rtl/pc_fetch_unit.sv | 136 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the fetch front end: FSM state encoding, fault causes and the fault record.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef logic [1:0] fcause_t;

  localparam fcause_t FC_NONE     = 2'b00;
  localparam fcause_t FC_MISALIGN = 2'b01;
  localparam fcause_t FC_TIMEOUT  = 2'b10;

  typedef struct packed {
    fcause_t         cause;
    logic [XLEN-1:0] addr;
  } fault_t;

  // J-type target: region bits come from pc+4, not pc.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                  input logic [XLEN-1:0] ins);
    return {pc4[31:28], ins[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Response watchdog: counts cycles spent waiting for fetch data.
// Latency: expired is combinational on the current count (no extra cycle).
// Backpressure: none; clr wins over en, counter holds when neither is set.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count;
  logic [16:0] count_inc;

  assign count_inc = {1'b0, count} + 17'd1;

  // Compare the incremented value so the FSM leaves WAIT on the same edge the count reaches TIMEOUT-1.
  assign expired = en && (count_inc >= 17'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc[15:0];
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-issue instruction fetch sequencer with response watchdog and sticky fault.
// Latency: zero-wait memory gives instr_valid one cycle after imem_req; commit-to-commit minimum 2 cycles.
// Backpressure: imem_req held until imem_gnt; stall holds the current instruction and PC indefinitely.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] jpc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            commit,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_in,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_addr
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  fault_t          flt_q;

  logic fetch_done;
  logic commit_ok;
  logic misalign;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;
  logic timeout_hit;

  // rvalid only counts in WAIT, or in REQ when it arrives with the grant.
  assign fetch_done  = ((state == S_REQ) && imem_gnt && imem_rvalid) ||
                       ((state == S_WAIT) && imem_rvalid);
  assign commit_ok   = (state == S_VALID) && commit && !stall;
  assign misalign    = (pc_in[1:0] != 2'b00);
  assign wd_clr      = (state != S_WAIT);
  assign wd_en       = (state == S_WAIT) && !imem_rvalid;
  assign timeout_hit = (state == S_WAIT) && !imem_rvalid && wd_expired;

  fetch_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_nxt = imem_rvalid ? S_VALID : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = S_VALID;
        end else if (wd_expired) begin
          state_nxt = S_FAULT;
        end
      end
      S_VALID: begin
        if (commit_ok) begin
          state_nxt = misalign ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    unique case (state)
      S_REQ:   imem_req    = 1'b1;
      S_VALID: instr_valid = 1'b1;
      S_FAULT: fault       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      flt_q   <= '{cause: FC_NONE, addr: '0};
    end else begin
      if (fetch_done) begin
        instr_q <= imem_rdata;
      end
      if (commit_ok && !misalign) begin
        pc_q <= pc_in;
      end
      if (commit_ok && misalign) begin
        flt_q <= '{cause: FC_MISALIGN, addr: pc_in};
      end else if (timeout_hit) begin
        flt_q <= '{cause: FC_TIMEOUT, addr: pc_q};
      end
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign jpc         = jump_target(pc_plus4, instr_q);
  assign instr       = instr_q;
  assign fault_cause = flt_q.cause;
  assign fault_addr  = flt_q.addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written reset/timeout sequences,
// and a randomized memory/commit agent checked against a transaction-level PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int unsigned TO  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, pc_plus4, jpc, instr;
  logic        instr_valid;
  logic        commit = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_in = '0;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .jpc(jpc), .instr(instr), .instr_valid(instr_valid),
    .commit(commit), .stall(stall), .pc_in(pc_in),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        cm;
    logic        st;
    logic [31:0] pcin;
    logic        req;
    logic        iv;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic [31:0] jpc;
    logic [31:0] faddr;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input int g, input int rv, input logic [31:0] rd,
                              input int cm, input int st, input logic [31:0] pi,
                              input int req, input int iv, input int flt, input int cause,
                              input logic [31:0] epc, input logic [31:0] ein,
                              input logic [31:0] epp4, input logic [31:0] ejpc,
                              input logic [31:0] efa);
    vec_t v;
    v.gnt = (g != 0);    v.rv = (rv != 0);  v.rdata = rd;
    v.cm = (cm != 0);    v.st = (st != 0);  v.pcin = pi;
    v.req = (req != 0);  v.iv = (iv != 0);  v.flt = (flt != 0);
    v.cause = 2'(cause); v.pc = epc;        v.instr = ein;
    v.pp4 = epp4;        v.jpc = ejpc;      v.faddr = efa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic cm, input logic st, input logic [31:0] pi);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    commit = cm;  stall = st;       pc_in = pi;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] jump_ref(input logic [31:0] p, input logic [31:0] w);
    return ((p + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
  endfunction

  // Random-phase model state
  logic [31:0] m_pc;
  bit          m_have, m_out, delivered;
  int          m_wait, m_dly, commits;
  logic        g, rv, cm, st;
  logic [31:0] rd, pi;

  initial begin
    localparam logic [31:0] PA4 = 32'h0040_0004;
    localparam logic [31:0] PB  = 32'h0040_0040;
    localparam logic [31:0] PB4 = 32'h0040_0044;
    localparam logic [31:0] PW  = 32'hFFFF_FFFC;

    //            gnt rv rdata          cm st pc_in          req iv flt cs pc   instr          pp4  jpc            faddr
    vecs[0]  = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0,             0, 0, 0, 0, RPC, 0,             PA4, 0,             0);
    vecs[1]  = mk(1, 1, 32'h2008_0005, 0, 0, 0,             1, 0, 0, 0, RPC, 0,             PA4, 0,             0);
    vecs[2]  = mk(0, 0, 0,             1, 0, RPC,           0, 1, 0, 0, RPC, 32'h2008_0005, PA4, 32'h0020_0014, 0);
    vecs[3]  = mk(1, 1, 32'h0810_0010, 0, 0, 0,             1, 0, 0, 0, RPC, 32'h2008_0005, PA4, 32'h0020_0014, 0);
    vecs[4]  = mk(0, 0, 0,             1, 0, PB,            0, 1, 0, 0, RPC, 32'h0810_0010, PA4, 32'h0040_0040, 0);
    vecs[5]  = mk(1, 0, 0,             0, 0, 0,             1, 0, 0, 0, PB,  32'h0810_0010, PB4, 32'h0040_0040, 0);
    vecs[6]  = mk(0, 0, 0,             0, 0, 0,             0, 0, 0, 0, PB,  32'h0810_0010, PB4, 32'h0040_0040, 0);
    vecs[7]  = mk(0, 0, 0,             1, 0, 32'h0040_0100, 0, 0, 0, 0, PB,  32'h0810_0010, PB4, 32'h0040_0040, 0);
    vecs[8]  = mk(0, 1, 32'h3C01_1234, 0, 0, 0,             0, 0, 0, 0, PB,  32'h0810_0010, PB4, 32'h0040_0040, 0);
    vecs[9]  = mk(0, 0, 0,             1, 1, PW,            0, 1, 0, 0, PB,  32'h3C01_1234, PB4, 32'h0004_48D0, 0);
    vecs[10] = mk(0, 0, 0,             1, 1, PW,            0, 1, 0, 0, PB,  32'h3C01_1234, PB4, 32'h0004_48D0, 0);
    vecs[11] = mk(0, 0, 0,             1, 1, PW,            0, 1, 0, 0, PB,  32'h3C01_1234, PB4, 32'h0004_48D0, 0);
    vecs[12] = mk(0, 0, 0,             1, 0, PW,            0, 1, 0, 0, PB,  32'h3C01_1234, PB4, 32'h0004_48D0, 0);
    vecs[13] = mk(1, 1, 32'h0BFF_FFFF, 0, 0, 0,             1, 0, 0, 0, PW,  32'h3C01_1234, 0,   32'h0004_48D0, 0);
    vecs[14] = mk(0, 0, 0,             1, 0, 32'h0040_0006, 0, 1, 0, 0, PW,  32'h0BFF_FFFF, 0,   32'h0FFF_FFFC, 0);
    vecs[15] = mk(1, 1, 32'h1234_5678, 0, 0, 0,             0, 0, 1, 1, PW,  32'h0BFF_FFFF, 0,   32'h0FFF_FFFC, 32'h0040_0006);
    vecs[16] = mk(0, 0, 0,             1, 0, 0,             0, 0, 1, 1, PW,  32'h0BFF_FFFF, 0,   32'h0FFF_FFFC, 32'h0040_0006);
    vecs[17] = mk(0, 0, 0,             0, 0, 0,             0, 0, 1, 1, PW,  32'h0BFF_FFFF, 0,   32'h0FFF_FFFC, 32'h0040_0006);

    // Directed table: cycle 0 is the S_RESET cycle right after release.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      chk($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].pc);
      chk($sformatf("v%0d_pc", i),    pc,               vecs[i].pc);
      chk($sformatf("v%0d_iv", i),    32'(instr_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d_instr", i), instr,            vecs[i].instr);
      chk($sformatf("v%0d_pp4", i),   pc_plus4,         vecs[i].pp4);
      chk($sformatf("v%0d_jpc", i),   jpc,              vecs[i].jpc);
      chk($sformatf("v%0d_fault", i), 32'(fault),       32'(vecs[i].flt));
      chk($sformatf("v%0d_cause", i), 32'(fault_cause), 32'(vecs[i].cause));
      chk($sformatf("v%0d_faddr", i), fault_addr,       vecs[i].faddr);
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].cm, vecs[i].st, vecs[i].pcin);
    end

    // Stray rvalid before grant, then grant without data: timeout 4 cycles after the grant.
    do_reset();
    step();
    chk("to_req1", 32'(imem_req), 32'd1);
    drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0);
    step();
    chk("to_req2", 32'(imem_req), 32'd1);
    chk("to_stray_iv", 32'(instr_valid), 32'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    chk("to_wait_req", 32'(imem_req), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    step();
    chk("to_edge_fault", 32'(fault), 32'd0);
    step();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd2);
    chk("to_faddr", fault_addr, RPC);
    drive(1'b1, 1'b1, 32'h1111_2222, 1'b1, 1'b0, 32'h0000_0100);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to_sticky", 32'(fault), 32'd1);
      chk("to_noreq", 32'(imem_req), 32'd0);
      chk("to_pc", pc, RPC);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_cause", 32'(fault_cause), 32'd0);
    chk("arst_faddr", fault_addr, 32'd0);

    // Reset asserted in the middle of a WAIT after the PC has moved.
    do_reset();
    step();
    drive(1'b1, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, '0);
    step();
    chk("mw_iv", 32'(instr_valid), 32'd1);
    chk("mw_instr", instr, 32'hCAFE_0001);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_1000);
    step();
    chk("mw_pc", pc, 32'h0000_1000);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    chk("mw_wait_req", 32'(imem_req), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mw_arst_pc", pc, RPC);
    chk("mw_arst_instr", instr, 32'd0);
    chk("mw_arst_req", 32'(imem_req), 32'd0);
    chk("mw_arst_iv", 32'(instr_valid), 32'd0);
    chk("mw_arst_pp4", pc_plus4, RPC + 32'd4);
    step();
    drive(1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, '0);
    rst = 1'b0;
    step();
    chk("mw_restart_req", 32'(imem_req), 32'd1);
    chk("mw_restart_addr", imem_addr, RPC);
    drive(1'b0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, '0);
    step();
    chk("mw_late_rv_iv", 32'(instr_valid), 32'd0);
    chk("mw_late_rv_req", 32'(imem_req), 32'd1);

    // Randomized memory latency (0..3 wait cycles, all inside the timeout) and commit/stall traffic.
    do_reset();
    m_pc = RPC; m_have = 0; m_out = 0; m_wait = 0; m_dly = 0; commits = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) step();
      chk("r_pc", pc, m_pc);
      chk("r_addr", imem_addr, m_pc);
      chk("r_pp4", pc_plus4, m_pc + 32'd4);
      chk("r_iv", 32'(instr_valid), 32'(m_have));
      chk("r_fault", 32'(fault), 32'd0);
      if (m_have) begin
        chk("r_instr", instr, memword(m_pc));
        chk("r_jpc", jpc, jump_ref(m_pc, memword(m_pc)));
      end
      if (m_have || m_out) chk("r_noreq", 32'(imem_req), 32'd0);

      g = 1'b0; rv = 1'b0; rd = $urandom(); delivered = 0;
      cm = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 2) == 0);
      pi = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      if (m_out) begin
        m_wait++;
        if (m_wait == m_dly) begin
          rv = 1'b1; rd = memword(m_pc); delivered = 1;
        end
      end else if (imem_req && $urandom_range(0, 3) != 0) begin
        g = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          rv = 1'b1; rd = memword(m_pc); delivered = 1;
        end else begin
          m_out = 1; m_wait = 0; m_dly = $urandom_range(1, 3);
        end
      end else begin
        rv = ($urandom_range(0, 3) == 0);
      end
      drive(g, rv, rd, cm, st, pi);

      if (delivered) begin
        m_have = 1; m_out = 0;
      end else if (m_have && cm && !st) begin
        m_have = 0; m_pc = pi; commits++;
      end
    end
    tests++;
    if (commits < 50) begin
      fails++;
      $display("FAIL r_progress: got %0d commits expected at least 50", commits);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
